// File: rtl/mem_rd_arbiter_pkg.sv
// Shared types and constants for the DDR read-port arbiter.
// Also holds the 4 KB boundary check used on every granted burst.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_t;

  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_OKAY       = 2'b00;
  localparam logic [1:0] AXI_SLVERR     = 2'b10;
  localparam int         MEM_ID_W       = 4;
  localparam int         LOCAL_ID_W     = 2;
  localparam int         CNT_W          = 4;

  // A 16-byte-beat INCR burst may not run past the end of its 4 KB page
  function automatic logic crosses_4k(input logic [11:0] page_off, input logic [7:0] len);
    logic [13:0] end_s;
    end_s = {2'b00, page_off} + (({6'b000000, len} + 14'd1) << 4);
    return end_s > 14'd4096;
  endfunction

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Requester-side AR/R bundle plus the AXI read master toward the memory controller.
// master = arbiter view, slave = requesters and memory controller view.
interface mem_rd_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 128
);
  logic [NUM_REQ-1:0]        req_arvalid;
  logic [NUM_REQ-1:0]        req_arready;
  logic [NUM_REQ*ADDR_W-1:0] req_araddr;
  logic [NUM_REQ*8-1:0]      req_arlen;
  logic [NUM_REQ*2-1:0]      req_arid;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [NUM_REQ-1:0]        req_rready;
  logic [DATA_W-1:0]         req_rdata;
  logic [1:0]                req_rid;
  logic [1:0]                req_rresp;
  logic                      req_rlast;

  logic                      mem_arvalid;
  logic                      mem_arready;
  logic [ADDR_W-1:0]         mem_araddr;
  logic [7:0]                mem_arlen;
  logic [3:0]                mem_arid;
  logic [2:0]                mem_arsize;
  logic [1:0]                mem_arburst;
  logic                      mem_arlock;
  logic                      mem_rvalid;
  logic                      mem_rready;
  logic [DATA_W-1:0]         mem_rdata;
  logic [3:0]                mem_rid;
  logic [1:0]                mem_rresp;
  logic                      mem_rlast;

  logic                      err_4k;
  logic                      err_rid;

  modport master (
    input  req_arvalid, req_araddr, req_arlen, req_arid, req_rready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rid, mem_rresp, mem_rlast,
    output req_arready, req_rvalid, req_rdata, req_rid, req_rresp, req_rlast,
    output mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_arsize, mem_arburst,
    output mem_arlock, mem_rready, err_4k, err_rid
  );

  modport slave (
    output req_arvalid, req_araddr, req_arlen, req_arid, req_rready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rid, mem_rresp, mem_rlast,
    input  req_arready, req_rvalid, req_rdata, req_rid, req_rresp, req_rlast,
    input  mem_arvalid, mem_araddr, mem_arlen, mem_arid, mem_arsize, mem_arburst,
    input  mem_arlock, mem_rready, err_4k, err_rid
  );
endinterface

// File: rtl/mem_rd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan N positions starting one past the pointer; the first hit wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 1; off <= N; off++) begin
      int j;
      j = (int'(ptr) + off) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin sharing of one AXI4 read port among NUM_REQ masters, with
// ID-based R routing and a per-requester cap on outstanding bursts.
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 128,
  parameter int MAX_OUTST = 4
) (
  input  logic           mem_clk,
  input  logic           mem_reset,
  mem_rd_arbiter_if.master bus
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t        state_r;
  logic [RW-1:0]     ptr_r;
  logic [CNT_W-1:0]  outst_r [NUM_REQ];
  logic [NUM_REQ-1:0] req_arready_r;
  logic              mem_arvalid_r;
  logic [ADDR_W-1:0] mem_araddr_r;
  logic [7:0]        mem_arlen_r;
  logic [3:0]        mem_arid_r;
  logic              err_4k_r;
  logic              err_rid_r;

  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [RW-1:0]      gnt_idx_s;
  logic               any_s;
  logic [1:0]         k_s;
  logic               rid_ok_s;
  logic [3:0]         rvalid_pad_s;
  logic [3:0]         rready_pad_s;
  logic               mem_rready_s;
  logic [NUM_REQ-1:0] inc_s;
  logic [NUM_REQ-1:0] dec_s;
  logic               underflow_s;

  rr_arbiter #(.N(NUM_REQ), .W(RW)) u_rr (
    .req (elig_s),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (gnt_idx_s),
    .any (any_s)
  );

  // Eligibility, R routing by the requester index carried in mem_rid[3:2], counter deltas
  always_comb begin
    k_s          = bus.mem_rid[3:2];
    rid_ok_s     = int'(k_s) < NUM_REQ;
    rready_pad_s = 4'(bus.req_rready);
    rvalid_pad_s = (rid_ok_s && bus.mem_rvalid) ? (4'b0001 << k_s) : 4'b0000;
    mem_rready_s = rid_ok_s ? rready_pad_s[k_s] : 1'b1;
    underflow_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = bus.req_arvalid[i] && (outst_r[i] < CNT_W'(MAX_OUTST));
      inc_s[i]  = (state_r == ARB_IDLE) && gnt_s[i];
      dec_s[i]  = bus.mem_rvalid && mem_rready_s && bus.mem_rlast && rid_ok_s
                  && (int'(k_s) == i);
      if (dec_s[i] && !inc_s[i] && (outst_r[i] == '0)) begin
        underflow_s = 1'b1;
      end else begin
        underflow_s = underflow_s;
      end
    end
  end

  // AR issue FSM, outstanding counters and sticky error flags
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state_r       <= ARB_IDLE;
      ptr_r         <= RW'(NUM_REQ - 1);
      req_arready_r <= '0;
      mem_arvalid_r <= 1'b0;
      mem_araddr_r  <= '0;
      mem_arlen_r   <= 8'd0;
      mem_arid_r    <= 4'd0;
      err_4k_r      <= 1'b0;
      err_rid_r     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_r[i] <= '0;
      end
    end else begin
      req_arready_r <= '0;
      case (state_r)
        ARB_IDLE: begin
          if (any_s) begin
            mem_araddr_r  <= bus.req_araddr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
            mem_arlen_r   <= bus.req_arlen[int'(gnt_idx_s)*8 +: 8];
            mem_arid_r    <= {2'(gnt_idx_s),
                              bus.req_arid[int'(gnt_idx_s)*LOCAL_ID_W +: LOCAL_ID_W]};
            mem_arvalid_r <= 1'b1;
            req_arready_r <= gnt_s;
            ptr_r         <= gnt_idx_s;
            state_r       <= ARB_ISSUE;
            if (crosses_4k(bus.req_araddr[int'(gnt_idx_s)*ADDR_W +: 12],
                           bus.req_arlen[int'(gnt_idx_s)*8 +: 8])) begin
              err_4k_r <= 1'b1;
            end
          end
        end
        ARB_ISSUE: begin
          if (mem_arvalid_r && bus.mem_arready) begin
            mem_arvalid_r <= 1'b0;
            state_r       <= ARB_IDLE;
          end
        end
        default: state_r <= ARB_IDLE;
      endcase
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10:   outst_r[i] <= outst_r[i] + CNT_W'(1);
          2'b01:   if (outst_r[i] != '0) outst_r[i] <= outst_r[i] - CNT_W'(1);
          default: outst_r[i] <= outst_r[i];
        endcase
      end
      if ((bus.mem_rvalid && !rid_ok_s) || underflow_s) begin
        err_rid_r <= 1'b1;
      end
    end
  end

  assign bus.req_arready = req_arready_r;
  assign bus.mem_arvalid = mem_arvalid_r;
  assign bus.mem_araddr  = mem_araddr_r;
  assign bus.mem_arlen   = mem_arlen_r;
  assign bus.mem_arid    = mem_arid_r;
  assign bus.mem_arsize  = AXI_SIZE_16B;
  assign bus.mem_arburst = AXI_BURST_INCR;
  assign bus.mem_arlock  = 1'b0;
  assign bus.err_4k      = err_4k_r;
  assign bus.err_rid     = err_rid_r;

  // The R channel is a straight combinational path; only valid/ready are steered
  assign bus.req_rvalid  = rvalid_pad_s[NUM_REQ-1:0];
  assign bus.mem_rready  = mem_rready_s;
  assign bus.req_rdata   = bus.mem_rdata;
  assign bus.req_rid     = bus.mem_rid[1:0];
  assign bus.req_rresp   = bus.mem_rresp;
  assign bus.req_rlast   = bus.mem_rlast;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboarded bench for mem_rd_arbiter: expected grants, AR transfers and routed
// R beats are queued by the stimulus and popped by independent monitors.
module tb_mem_rd_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 128;

  logic mem_clk;
  logic mem_reset;
  int   total;
  int   bad;

  mem_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_rd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(4)) dut (
    .mem_clk   (mem_clk),
    .mem_reset (mem_reset),
    .bus       (bus)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int                 gnt_q [$];
  logic [38:0]        ar_q  [$];
  logic [134:0]       r_q   [$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Grant monitor: each req_arready pulse must match the next expected index
  always @(negedge mem_clk) begin
    if (!mem_reset && bus.req_arready != 2'b00) begin
      if (gnt_q.size() == 0) check("unexpected_gnt", 160'(bus.req_arready), 160'd0);
      else check("gnt_order", 160'(bus.req_arready), 160'(2'b01 << gnt_q.pop_front()));
    end
  end

  // AR monitor: every memory-side handshake must carry the expected fields
  always @(negedge mem_clk) begin
    if (!mem_reset && bus.mem_arvalid && bus.mem_arready) begin
      if (ar_q.size() == 0) check("unexpected_ar", 160'(bus.mem_araddr), 160'd0);
      else check("ar_fields", 160'({bus.mem_araddr, bus.mem_arlen, bus.mem_arid}),
                 160'(ar_q.pop_front()));
    end
  end

  // R monitor: every accepted routed beat must match the next expected beat
  always @(negedge mem_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!mem_reset && bus.req_rvalid[i] && bus.req_rready[i]) begin
        if (r_q.size() == 0) check("unexpected_r", 160'(i), 160'hff);
        else check("r_beat", 160'({2'(i), bus.req_rdata, bus.req_rid, bus.req_rresp,
                                   bus.req_rlast}), 160'(r_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [26:0] addr, input logic [7:0] len,
                         input logic [1:0] id);
    bus.req_araddr[i*ADDR_W +: ADDR_W] = addr;
    bus.req_arlen[i*8 +: 8]            = len;
    bus.req_arid[i*2 +: 2]             = id;
    bus.req_arvalid[i]                 = 1'b1;
  endtask

  task automatic wait_gnt(input int i);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.req_arready[i] && n < 50);
    if (n >= 50) check("gnt_timeout", 160'(i), 160'hff);
  endtask

  task automatic beat(input logic [3:0] rid, input logic [127:0] data,
                      input logic [1:0] resp, input logic last);
    bus.mem_rvalid = 1'b1;
    bus.mem_rid    = rid;
    bus.mem_rdata  = data;
    bus.mem_rresp  = resp;
    bus.mem_rlast  = last;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
  endtask

  task automatic do_reset();
    mem_reset = 1'b1;
    tick();
    mem_reset = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mem_reset       = 1'b1;
    bus.req_arvalid = '0;
    bus.req_araddr  = '0;
    bus.req_arlen   = '0;
    bus.req_arid    = '0;
    bus.req_rready  = '0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rid     = 4'd0;
    bus.mem_rresp   = 2'b00;
    bus.mem_rlast   = 1'b0;
    tick();
    tick();
    check("rst_arvalid", 160'({bus.mem_arvalid, bus.req_arready}), 160'd0);
    check("rst_ar_fields", 160'({bus.mem_araddr, bus.mem_arlen, bus.mem_arid}), 160'd0);
    check("rst_ar_const", 160'({bus.mem_arsize, bus.mem_arburst, bus.mem_arlock}),
          160'({3'b100, 2'b01, 1'b0}));
    check("rst_err", 160'({bus.err_4k, bus.err_rid}), 160'd0);
    mem_reset = 1'b0;
    tick();

    // 1: single req0 burst, five beats routed to req0 only
    bus.mem_arready = 1'b1;
    bus.req_rready  = 2'b11;
    gnt_q.push_back(0);
    ar_q.push_back({27'h100, 8'd4, 4'b0000});
    set_req(0, 27'h100, 8'd4, 2'b00);
    wait_gnt(0);
    bus.req_arvalid[0] = 1'b0;
    tick();
    for (int b = 0; b < 5; b++) begin
      r_q.push_back({2'd0, 128'(32'hA000 + b), 2'b00, 2'b00, (b == 4)});
      bus.mem_rvalid = 1'b1;
      bus.mem_rid    = 4'b0000;
      #1;
      check("t1_route", 160'(bus.req_rvalid), 160'(2'b01));
      beat(4'b0000, 128'(32'hA000 + b), 2'b00, (b == 4));
    end

    // 2: both held; pointer sits at 0 after test 1, so grants go 1,0,1,0
    gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0);
    ar_q.push_back({27'h2000, 8'd0, 4'b0110});
    ar_q.push_back({27'h1000, 8'd1, 4'b0001});
    ar_q.push_back({27'h2000, 8'd0, 4'b0110});
    ar_q.push_back({27'h1000, 8'd1, 4'b0001});
    set_req(0, 27'h1000, 8'd1, 2'b01);
    set_req(1, 27'h2000, 8'd0, 2'b10);
    wait_gnt(1); wait_gnt(0); wait_gnt(1); wait_gnt(0);
    bus.req_arvalid = 2'b00;
    tick();
    r_q.push_back({2'd1, 128'hBEEF, 2'b10, 2'b10, 1'b1});
    beat(4'b0110, 128'hBEEF, 2'b10, 1'b1);
    r_q.push_back({2'd0, 128'hCAFE, 2'b01, 2'b00, 1'b1});
    beat(4'b0001, 128'hCAFE, 2'b00, 1'b1);
    do_reset();

    // 3: req0 fills its four slots, stalls, req1 still served, one rlast frees req0
    for (int g = 0; g < 4; g++) begin
      gnt_q.push_back(0);
      ar_q.push_back({27'h300, 8'd0, 4'b0000});
    end
    set_req(0, 27'h300, 8'd0, 2'b00);
    for (int g = 0; g < 4; g++) wait_gnt(0);
    repeat (10) tick();
    gnt_q.push_back(1);
    ar_q.push_back({27'h400, 8'd0, 4'b0111});
    set_req(1, 27'h400, 8'd0, 2'b11);
    wait_gnt(1);
    bus.req_arvalid[1] = 1'b0;
    repeat (4) tick();
    gnt_q.push_back(0);
    ar_q.push_back({27'h300, 8'd0, 4'b0000});
    r_q.push_back({2'd0, 128'h55, 2'b00, 2'b00, 1'b1});
    beat(4'b0000, 128'h55, 2'b00, 1'b1);
    wait_gnt(0);
    bus.req_arvalid[0] = 1'b0;
    repeat (3) tick();
    do_reset();

    // 4: mem_arready low for 20 cycles keeps AR stable and blocks req1
    bus.mem_arready = 1'b0;
    gnt_q.push_back(0);
    gnt_q.push_back(1);
    ar_q.push_back({27'h5A0, 8'd3, 4'b0010});
    ar_q.push_back({27'h7C0, 8'd2, 4'b0101});
    set_req(0, 27'h5A0, 8'd3, 2'b10);
    set_req(1, 27'h7C0, 8'd2, 2'b01);
    wait_gnt(0);
    bus.req_arvalid[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t4_stable", 160'({bus.mem_arvalid, bus.mem_araddr, bus.mem_arlen, bus.mem_arid,
                               bus.req_arready}),
            160'({1'b1, 27'h5A0, 8'd3, 4'b0010, 2'b00}));
    end
    bus.mem_arready = 1'b1;
    wait_gnt(1);
    bus.req_arvalid[1] = 1'b0;
    repeat (3) tick();
    do_reset();

    // 5: exact page end is legal, one beat past sets err_4k; bad rid is dropped
    gnt_q.push_back(0);
    ar_q.push_back({27'hFE0, 8'd1, 4'b0000});
    set_req(0, 27'hFE0, 8'd1, 2'b00);
    wait_gnt(0);
    bus.req_arvalid[0] = 1'b0;
    tick();
    check("t5_no_4k", 160'(bus.err_4k), 160'd0);
    gnt_q.push_back(0);
    ar_q.push_back({27'hFF0, 8'd1, 4'b0000});
    set_req(0, 27'hFF0, 8'd1, 2'b00);
    wait_gnt(0);
    bus.req_arvalid[0] = 1'b0;
    check("t5_err_4k", 160'(bus.err_4k), 160'd1);
    tick();
    bus.req_rready = 2'b00;
    bus.mem_rvalid = 1'b1;
    bus.mem_rid    = 4'b1100;
    #1;
    check("t5_drop", 160'({bus.mem_rready, bus.req_rvalid}), 160'({1'b1, 2'b00}));
    check("t5_rid_pre", 160'(bus.err_rid), 160'd0);
    beat(4'b1100, 128'h77, 2'b00, 1'b1);
    check("t5_err_rid", 160'(bus.err_rid), 160'd1);
    bus.req_rready = 2'b11;
    do_reset();

    // 6: reset while an AR is pending clears everything at once
    bus.mem_arready = 1'b0;
    gnt_q.push_back(0);
    set_req(0, 27'hFF0, 8'd1, 2'b01);
    wait_gnt(0);
    bus.req_arvalid[0] = 1'b0;
    tick();
    check("t6_pending", 160'({bus.mem_arvalid, bus.mem_araddr, bus.err_4k}),
          160'({1'b1, 27'hFF0, 1'b1}));
    mem_reset = 1'b1;
    #1;
    check("t6_async_clr", 160'({bus.mem_arvalid, bus.err_4k, bus.err_rid, bus.mem_araddr}),
          160'd0);
    tick();
    mem_reset = 1'b0;
    tick();
    r_q.push_back({2'd0, 128'h99, 2'b01, 2'b00, 1'b1});
    beat(4'b0001, 128'h99, 2'b00, 1'b1);
    check("t6_underflow", 160'({bus.err_rid, bus.mem_arvalid}), 160'({1'b1, 1'b0}));
    repeat (2) tick();

    check("q_empty", 160'({gnt_q.size() == 0, ar_q.size() == 0, r_q.size() == 0}),
          160'(3'b111));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
